fifo_param_sync: RTL

- Parametrised synchronous FIFO. Generalises the team's fixed 16-bit FIFO with:
  - configurable width and depth;
  - programmable almost-full and almost-empty thresholds;
  - an occupancy count output;
  - a selectable first-word-fall-through (FWFT) read mode.
- Keeps the existing status set: wr_ack, overflow, underflow, full, empty, almost_full, almost_empty.
- Drop-in for existing benches at default parameters.

---
 rtl/fifo_param_sync.sv | 95 +++++++++
 1 files changed

// File: rtl/fifo_param_sync.sv
// Parametrised synchronous FIFO: configurable width/depth, programmable almost
// thresholds, occupancy count and optional first-word-fall-through read port.
module fifo_param_sync #(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int AF_THRESH  = FIFO_DEPTH - 1,
    parameter int AE_THRESH  = 1,
    parameter int FWFT       = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [FIFO_WIDTH-1:0]         data_in,
    input  logic                          wr_en,
    input  logic                          rd_en,
    output logic [FIFO_WIDTH-1:0]         data_out,
    output logic                          wr_ack,
    output logic                          overflow,
    output logic                          underflow,
    output logic                          full,
    output logic                          empty,
    output logic                          almost_full,
    output logic                          almost_empty,
    output logic [$clog2(FIFO_DEPTH):0]   count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         cnt;
    logic                  wr_acc;
    logic                  rd_acc;

    // Status flags decode straight from the registered occupancy.
    always_comb begin
        full         = (cnt == CW'(FIFO_DEPTH));
        empty        = (cnt == '0);
        almost_full  = (cnt >= CW'(AF_THRESH)) && !full;
        almost_empty = (cnt != '0) && (cnt <= CW'(AE_THRESH));
        wr_acc       = wr_en && !full;
        rd_acc       = rd_en && !empty;
        count        = cnt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt       <= '0;
            wr_ack    <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            wr_ack    <= wr_acc;
            overflow  <= wr_en && !wr_acc;
            underflow <= rd_en && !rd_acc;
            if (wr_acc)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc)
                rd_ptr <= rd_ptr + 1'b1;
            if (wr_acc && !rd_acc)
                cnt <= cnt + 1'b1;
            else if (rd_acc && !wr_acc)
                cnt <= cnt - 1'b1;
        end
    end

    // Storage is not cleared on reset; only the write is suppressed.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc)
            mem[wr_ptr] <= data_in;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            always_comb begin
                data_out = empty ? '0 : mem[rd_ptr];
            end
        end else begin : g_std
            logic [FIFO_WIDTH-1:0] dout_q;
            always_ff @(posedge clk) begin
                if (rst)
                    dout_q <= '0;
                else if (rd_acc)
                    dout_q <= mem[rd_ptr];
            end
            always_comb begin
                data_out = dout_q;
            end
        end
    endgenerate

endmodule
